// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and an occupancy counter.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    // A push is refused while full even if the same edge pops.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter fed from an internal byte FIFO; frames stream
// back-to-back while the FIFO holds data.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 57600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk_25mhz,
    input  logic                              rst_n,
    input  logic [DATA_BITS-1:0]              in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              tx,
    output logic                              busy,
    output logic                              tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx_fifo: illegal parameter set");
    end

    tx_state_t              r_state;
    tx_state_t              w_state_nxt;
    logic [BW-1:0]          r_baud_cnt;
    logic [2:0]             r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_parity;
    logic                   w_tick;
    logic                   w_last_data;
    logic                   w_last_stop;
    logic                   w_pop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [DATA_BITS-1:0]   w_fifo_rdata;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_25mhz),
        .rst_n   (rst_n),
        .i_push  (in_valid),
        .i_wdata (in_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count)
    );

    assign in_ready    = !w_fifo_full;
    assign busy        = (r_state != S_IDLE) || (fifo_count != '0);
    assign w_tick      = (r_baud_cnt == BW'(DIV - 1));
    assign w_last_data = (r_bit_cnt == 3'(DATA_BITS - 1));
    assign w_last_stop = (r_bit_cnt == 3'(STOP_BITS - 1));

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (!w_fifo_empty) w_state_nxt = S_START;
            S_START:  if (w_tick) w_state_nxt = S_DATA;
            S_DATA:   if (w_tick && w_last_data)
                          w_state_nxt = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
            S_PARITY: if (w_tick) w_state_nxt = S_STOP;
            S_STOP:   if (w_tick && w_last_stop)
                          w_state_nxt = w_fifo_empty ? S_IDLE : S_START;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx      = 1'b1;
        tx_done = 1'b0;
        case (r_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = r_shift[0];
            S_PARITY: tx = r_parity;
            S_STOP:   tx_done = w_tick && w_last_stop;
            default:  tx = 1'b1;
        endcase
        // START is only ever entered from IDLE or the end of STOP, both of which consume a byte.
        w_pop = (w_state_nxt == S_START) && (r_state != S_START);
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            if (w_state_nxt != r_state || w_tick) r_baud_cnt <= '0;
            else                                  r_baud_cnt <= r_baud_cnt + 1'b1;
            if (w_state_nxt != r_state || (r_state == S_STOP && w_tick && w_last_stop))
                r_bit_cnt <= '0;
            else if (w_tick && (r_state == S_DATA || r_state == S_STOP))
                r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (w_pop) begin
            r_shift  <= w_fifo_rdata;
            r_parity <= (^w_fifo_rdata) ^ (PARITY == PARITY_ODD);
        end else if (r_state == S_DATA && w_tick) begin
            r_shift  <= r_shift >> 1;
        end
    end

endmodule
